// File: rtl/pe_pkg.sv
// Types and helpers shared by every processing-element block.
// PE_STATE is the status tag that travels beside the datapath.
package pe_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    VALID   = 2'd1,
    CNN_FIN = 2'd2,
    COMPL   = 2'd3
  } PE_STATE;

  // Number of live nodes at level 'lvl' of a pairwise reduction of 'n' inputs.
  // An odd node rides up unchanged, which is why the count rounds up.
  function automatic int tree_level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage

// File: rtl/adder_tree_comb.sv
// Purely combinational balanced adder tree: ADD_NUM signed operands summed
// modulo 2^DATA_WID with ceil(log2 ADD_NUM) levels of two-input adders.
module adder_tree_comb
  import pe_pkg::*;
#(
  parameter int DATA_WID = 8,
  parameter int ADD_NUM  = 4
) (
  input  logic signed [DATA_WID-1:0] i_data [ADD_NUM-1:0],
  output logic signed [DATA_WID-1:0] o_sum
);

  localparam int LEVELS = $clog2(ADD_NUM);

  // Row l holds the partial sums entering level l; row LEVELS has the result in slot 0.
  logic signed [DATA_WID-1:0] w_lvl [0:LEVELS][0:ADD_NUM-1];

  genvar g_l, g_i;

  generate
    for (g_i = 0; g_i < ADD_NUM; g_i++) begin : g_leaf
      assign w_lvl[0][g_i] = i_data[g_i];
    end

    for (g_l = 0; g_l < LEVELS; g_l++) begin : g_level
      localparam int CNT = tree_level_count(ADD_NUM, g_l);
      for (g_i = 0; g_i < ADD_NUM; g_i++) begin : g_node
        if (g_i < CNT / 2) begin : g_add
          assign w_lvl[g_l+1][g_i] = w_lvl[g_l][2*g_i] + w_lvl[g_l][2*g_i+1];
        end else if ((g_i == CNT / 2) && ((CNT % 2) == 1)) begin : g_pass
          assign w_lvl[g_l+1][g_i] = w_lvl[g_l][CNT-1];
        end else begin : g_idle
          assign w_lvl[g_l+1][g_i] = '0;
        end
      end
    end
  endgenerate

  assign o_sum = w_lvl[LEVELS][0];

endmodule

// File: rtl/adder_pipe.sv
// Registered signed adder tree for the PE datapath: one cycle from operands
// to sum, with the status tag registered alongside so both arrive together.
module adder_pipe
  import pe_pkg::*;
#(
  parameter int DATA_WID = 8,
  parameter int ADD_NUM  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  PE_STATE                    status_in,
  input  logic signed [DATA_WID-1:0] data_in [ADD_NUM-1:0],
  output PE_STATE                    status_out,
  output logic signed [DATA_WID-1:0] data_out
);

  // Flow semantics: no valid/ready handshake. A new operand set is accepted
  // every cycle; status_in != INVALID plays the role of 'valid', and there is
  // no backpressure. data_out only carries meaning while status_out != INVALID,
  // and it holds its last value across INVALID cycles.

  logic signed [DATA_WID-1:0] w_sum;
  logic signed [DATA_WID-1:0] r_data;
  PE_STATE                    r_status;

  adder_tree_comb #(
    .DATA_WID (DATA_WID),
    .ADD_NUM  (ADD_NUM)
  ) u_tree (
    .i_data (data_in),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_status <= INVALID;
    end else begin
      r_status <= status_in;
      if (status_in != INVALID) begin
        r_data <= w_sum;
      end
    end
  end

  assign data_out   = r_data;
  assign status_out = r_status;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed-vector bench for adder_pipe with a queue-based scoreboard; a
// 3-operand instance runs beside the default one to exercise the odd pass-through.
module tb_adder_pipe;
  import pe_pkg::*;

  localparam int W = 18;  // {status[1:0], sum4[7:0], sum3[7:0]}

  logic              clk;
  logic              reset;
  PE_STATE           status_in;
  logic signed [7:0] data_in  [3:0];
  logic signed [7:0] data_in3 [2:0];
  PE_STATE           status_out;
  PE_STATE           status_out3;
  logic signed [7:0] data_out;
  logic signed [7:0] data_out3;

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  adder_pipe #(.DATA_WID(8), .ADD_NUM(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .status_in  (status_in),
    .data_in    (data_in),
    .status_out (status_out),
    .data_out   (data_out)
  );

  adder_pipe #(.DATA_WID(8), .ADD_NUM(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .status_in  (status_in),
    .data_in    (data_in3),
    .status_out (status_out3),
    .data_out   (data_out3)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply one operand set before the next edge and record what must come out
  task automatic drive(input PE_STATE st, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] a3,
                       input logic [7:0] e4, input logic [7:0] e3);
    @(negedge clk);
    status_in   = st;
    data_in[0]  = a0;
    data_in[1]  = a1;
    data_in[2]  = a2;
    data_in[3]  = a3;
    data_in3[0] = a0;
    data_in3[1] = a1;
    data_in3[2] = a2;
    exp_q.push_back({st, e4, e3});
  endtask

  // monitor / scoreboard: outputs are sampled 1 time unit after each rising edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("status4", {6'd0, status_out},  {6'd0, e[17:16]});
        check("status3", {6'd0, status_out3}, {6'd0, e[17:16]});
        check("sum4",    data_out,            e[15:8]);
        check("sum3",    data_out3,           e[7:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data4"},   data_out,             8'h00);
    check({tag, "_data3"},   data_out3,            8'h00);
    check({tag, "_status4"}, {6'd0, status_out},   8'h00);
    check({tag, "_status3"}, {6'd0, status_out3},  8'h00);
  endtask

  initial begin
    int guard;
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    status_in   = INVALID;
    data_in[0]  = 8'h01;
    data_in[1]  = 8'haa;
    data_in[2]  = 8'haa;
    data_in[3]  = 8'haa;
    data_in3[0] = 8'h01;
    data_in3[1] = 8'haa;
    data_in3[2] = 8'haa;
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    reset = 1'b0;

    // status, a0..a3, expected sum of 4, expected sum of first 3
    drive(VALID,   8'haa, 8'haa, 8'h08, 8'h05, 8'h61, 8'h5c);
    drive(CNN_FIN, 8'haa, 8'haa, 8'haa, 8'haa, 8'ha8, 8'hfe);
    drive(COMPL,   8'haa, 8'haa, 8'haa, 8'haa, 8'ha8, 8'hfe);
    drive(VALID,   8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'hfc, 8'h7d);
    drive(INVALID, 8'h01, 8'h02, 8'h03, 8'h04, 8'hfc, 8'h7d);
    drive(VALID,   8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(VALID,   8'hff, 8'h01, 8'h7f, 8'h80, 8'hff, 8'h7f);
    drive(INVALID, 8'h11, 8'h22, 8'h33, 8'h44, 8'hff, 8'h7f);
    drive(VALID,   8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 8'h03);

    // reset asserted between edges while the outputs show VALID
    @(negedge clk);
    status_in = VALID;
    reset     = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    check_reset_outputs("rst_mid_hold");
    reset = 1'b0;
    drive(VALID,   8'h01, 8'h02, 8'h03, 8'h04, 8'h0a, 8'h06);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results never checked, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
